irq_pending_ctrl: RTL and testbench
===================================

IRQ_PENDING_CTRL -- requirements
Module: irq_pending_ctrl

Interface
REQ-001 The block SHALL have parameter-free ports exactly as listed in REQ-002 to REQ-011, with the clock and reset listed first.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  8  level request lines; a 0->1 transition on a bit SHALL post a request for that bit.
REQ-005 mask  input  8  enable per bit (1 = enabled, 0 = masked).
REQ-006 enc_a  output  8  priority-encoder input, equal to pending AND mask.
REQ-007 enc_y  input  3  index returned by the downstream 8-to-3 priority encoder (highest set bit of enc_a).
REQ-008 enc_valid  input  1  encoder valid: 1 when enc_a is nonzero.
REQ-009 irq  output  1  registered; service request to the consumer.
REQ-010 irq_id  output  3  registered; index being serviced, valid while irq=1.
REQ-011 ack  input  1  consumer acknowledge (level) and pending  output  8  registered pending vector.

Function
REQ-012 Edge detect: the block SHALL register req into req_q each cycle; rise = req AND NOT req_q.
REQ-013 Every rising edge with rise[i]=1 SHALL set pending[i], regardless of mask or FSM state.
REQ-014 Masked bits SHALL remain pending and SHALL become serviceable when mask[i] returns to 1.
REQ-015 enc_a SHALL be combinational: pending AND mask, with no added register.
REQ-016 The FSM SHALL have exactly three states: IDLE, ISSUE and RELEASE.
REQ-017 In IDLE with enc_valid=1, the block SHALL, at the next edge, latch irq_id<=enc_y, set irq=1 and enter ISSUE.
REQ-018 In IDLE with enc_valid=0, irq SHALL be 0 and irq_id SHALL hold its value.
REQ-019 In ISSUE, irq=1 and irq_id SHALL be held stable whatever the changes on req, mask or enc_y, including a higher-priority arrival.
REQ-020 In ISSUE, an edge sampling ack=1 SHALL clear pending[irq_id], drive irq=0 and enter RELEASE.
REQ-021 In RELEASE, the FSM SHALL stay while ack=1 and return to IDLE on the first edge sampling ack=0.
REQ-022 No new irq SHALL be issued from RELEASE, so each acknowledge services exactly one request.
REQ-023 ack=1 in IDLE SHALL be ignored, with no pending change and no state change.
REQ-024 When a clear and a new rise target the same bit on the same edge, set SHALL win (pending stays 1).
REQ-025 Latency: a rise sampled at edge k SHALL give pending[i]=1 after edge k and irq=1 after edge k+1, when in IDLE and enabled.
REQ-026 Minimum turnaround SHALL be ISSUE -> RELEASE -> IDLE -> ISSUE, so that back-to-back services are spaced at least 3 cycles apart.
REQ-027 If mask clears the serviced bit during ISSUE, irq SHALL stay 1 until ack; the ack SHALL still clear pending[irq_id].

Reset
REQ-028 rst_n=0 SHALL force immediately: state=IDLE, pending=8'h00, req_q=8'h00, irq=0, irq_id=3'd0.
REQ-029 Reset asserted mid-ISSUE SHALL drop irq asynchronously and discard all pending requests.
REQ-030 After deassertion, a req bit already high SHALL count as a rise on the first edge (req_q=0), and SHALL be posted.
REQ-031 enc_a SHALL be 8'h00 during reset, since pending=0.

Verification
REQ-032 Single request: mask=FF, req 00->08 -> pending=08 after that edge; irq=1 and irq_id=3 one edge later; ack one cycle -> pending=00, irq=0; ack low -> IDLE.
REQ-033 Priority: req rises on bits 1 and 6 on the same edge -> irq_id=6 first; after the ack/release cycle, irq_id=1.
REQ-034 Preemption blocked: in ISSUE with irq_id=2, bit 7 rises -> irq_id stays 2 until ack; next service is irq_id=7.
REQ-035 Masking: mask=7F, req bit 7 rises -> pending=80, enc_a=00, irq=0; mask to FF -> irq=1 with irq_id=7 one edge later.
REQ-036 Set/clear collision: bit 4 being acked while req[4] re-rises on the same edge -> pending[4] stays 1 and is re-issued after RELEASE.
REQ-037 Reset mid-operation: rst_n low during ISSUE -> irq=0, pending=00 with no clock edge; held ack across reset exit -> no spurious clear.

Source files
------------

// File: rtl/irq_pending_ctrl_if.sv
// Bus between the interrupt pending controller and its environment
// (request sources, downstream priority encoder and interrupt consumer).
interface irq_pending_ctrl_if;
  logic [7:0] req;
  logic [7:0] mask;
  logic [7:0] enc_a;
  logic [2:0] enc_y;
  logic       enc_valid;
  logic       irq;
  logic [2:0] irq_id;
  logic       ack;
  logic [7:0] pending;

  // Environment side: drives requests, mask, encoder result and acknowledge.
  modport master (
    output req, mask, enc_y, enc_valid, ack,
    input  enc_a, irq, irq_id, pending
  );

  // Controller side.
  modport slave (
    input  req, mask, enc_y, enc_valid, ack,
    output enc_a, irq, irq_id, pending
  );
endinterface

// File: rtl/irq_pending_ctrl.sv
// Edge-triggered interrupt pending register with a three-state issue/ack
// handshake; priority selection is delegated to an external 8-to-3 encoder.
module irq_pending_ctrl (
  input  logic              clk,
  input  logic              rst_n,
  irq_pending_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] req_q;
  logic [7:0] pending_q, pending_d;
  logic       irq_q, irq_d;
  logic [2:0] irq_id_q, irq_id_d;
  logic [7:0] rise;
  logic [7:0] clr;

  // NOTE: every variable gets a default at the top of always_comb so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    rise     = bus.req & ~req_q;
    clr      = 8'h00;
    state_d  = state_q;
    irq_d    = irq_q;
    irq_id_d = irq_id_q;

    case (state_q)
      IDLE: begin
        if (bus.enc_valid) begin
          irq_d    = 1'b1;
          irq_id_d = bus.enc_y;
          state_d  = ISSUE;
        end else begin
          irq_d = 1'b0;
        end
      end
      ISSUE: begin
        // irq_id stays frozen here, even if a higher-priority bit arrives.
        if (bus.ack) begin
          clr     = 8'h01 << irq_id_q;
          irq_d   = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        irq_d = 1'b0;
        if (!bus.ack) state_d = IDLE;
      end
      default: begin
        irq_d   = 1'b0;
        state_d = IDLE;
      end
    endcase

    // A new rise on the bit being cleared takes precedence.
    pending_d = (pending_q & ~clr) | rise;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops
  // sample the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= 8'h00;
      pending_q <= 8'h00;
      irq_q     <= 1'b0;
      irq_id_q  <= 3'd0;
    end else begin
      state_q   <= state_d;
      req_q     <= bus.req;
      pending_q <= pending_d;
      irq_q     <= irq_d;
      irq_id_q  <= irq_id_d;
    end
  end

  assign bus.enc_a   = pending_q & bus.mask;
  assign bus.irq     = irq_q;
  assign bus.irq_id  = irq_id_q;
  assign bus.pending = pending_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Self-checking bench for irq_pending_ctrl: vector table driven through a
// scoreboard queue, plus a hand-written asynchronous reset sequence.
module tb_irq_pending_ctrl;

  logic clk;
  logic rst_n;

  irq_pending_ctrl_if bus ();

  irq_pending_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream priority encoder: index of the highest set bit of enc_a.
  always_comb begin
    bus.enc_y     = 3'd0;
    bus.enc_valid = |bus.enc_a;
    for (int i = 0; i < 8; i++) begin
      if (bus.enc_a[i]) bus.enc_y = 3'(i);
    end
  end

  typedef struct {
    logic [7:0] pending;
    logic       irq;
    logic [2:0] irq_id;
    logic [7:0] enc_a;
  } exp_t;

  typedef struct {
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    exp_t       exp;
  } vec_t;

  vec_t tbl[$];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %02h, expected %02h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, " pending"}, bus.pending, e.pending);
    check({tag, " irq"}, {7'd0, bus.irq}, {7'd0, e.irq});
    check({tag, " irq_id"}, {5'd0, bus.irq_id}, {5'd0, e.irq_id});
    check({tag, " enc_a"}, bus.enc_a, e.enc_a);
  endtask

  // Drive one cycle of inputs, queue what must appear after the next edge,
  // then sample just after that edge and compare against the queue head.
  task automatic step(input string tag, input logic [7:0] req, input logic [7:0] mask,
                      input logic ack, input exp_t e);
    exp_t got_e;
    bus.req  = req;
    bus.mask = mask;
    bus.ack  = ack;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got_e = sb_q.pop_front();
    check_outputs(tag, got_e);
  endtask

  function automatic vec_t mk(input logic [7:0] req, input logic [7:0] mask, input logic ack,
                              input logic [7:0] p, input logic irq, input logic [2:0] id,
                              input logic [7:0] ea);
    vec_t v;
    v.req         = req;
    v.mask        = mask;
    v.ack         = ack;
    v.exp.pending = p;
    v.exp.irq     = irq;
    v.exp.irq_id  = id;
    v.exp.enc_a   = ea;
    return v;
  endfunction

  function automatic exp_t ex(input logic [7:0] p, input logic irq, input logic [2:0] id,
                              input logic [7:0] ea);
    exp_t e;
    e.pending = p;
    e.irq     = irq;
    e.irq_id  = id;
    e.enc_a   = ea;
    return e;
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //              req    mask   ack  pend   irq  id    enc_a
    // single request on bit 3
    tbl.push_back(mk(8'h00, 8'hFF, 0, 8'h00, 0, 3'd0, 8'h00));
    tbl.push_back(mk(8'h08, 8'hFF, 0, 8'h08, 0, 3'd0, 8'h08));
    tbl.push_back(mk(8'h08, 8'hFF, 0, 8'h08, 1, 3'd3, 8'h08));
    tbl.push_back(mk(8'h08, 8'hFF, 1, 8'h00, 0, 3'd3, 8'h00));
    tbl.push_back(mk(8'h08, 8'hFF, 0, 8'h00, 0, 3'd3, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 0, 8'h00, 0, 3'd3, 8'h00));
    // priority: bits 1 and 6 together, ack held two cycles
    tbl.push_back(mk(8'h42, 8'hFF, 0, 8'h42, 0, 3'd3, 8'h42));
    tbl.push_back(mk(8'h42, 8'hFF, 0, 8'h42, 1, 3'd6, 8'h42));
    tbl.push_back(mk(8'h42, 8'hFF, 1, 8'h02, 0, 3'd6, 8'h02));
    tbl.push_back(mk(8'h42, 8'hFF, 1, 8'h02, 0, 3'd6, 8'h02));
    tbl.push_back(mk(8'h42, 8'hFF, 0, 8'h02, 0, 3'd6, 8'h02));
    tbl.push_back(mk(8'h42, 8'hFF, 0, 8'h02, 1, 3'd1, 8'h02));
    tbl.push_back(mk(8'h42, 8'hFF, 1, 8'h00, 0, 3'd1, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 0, 8'h00, 0, 3'd1, 8'h00));
    // preemption blocked: bit 7 arrives while bit 2 is issued
    tbl.push_back(mk(8'h04, 8'hFF, 0, 8'h04, 0, 3'd1, 8'h04));
    tbl.push_back(mk(8'h04, 8'hFF, 0, 8'h04, 1, 3'd2, 8'h04));
    tbl.push_back(mk(8'h84, 8'hFF, 0, 8'h84, 1, 3'd2, 8'h84));
    tbl.push_back(mk(8'h84, 8'hFF, 0, 8'h84, 1, 3'd2, 8'h84));
    tbl.push_back(mk(8'h84, 8'hFF, 1, 8'h80, 0, 3'd2, 8'h80));
    tbl.push_back(mk(8'h84, 8'hFF, 0, 8'h80, 0, 3'd2, 8'h80));
    tbl.push_back(mk(8'h84, 8'hFF, 0, 8'h80, 1, 3'd7, 8'h80));
    tbl.push_back(mk(8'h84, 8'hFF, 1, 8'h00, 0, 3'd7, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 0, 8'h00, 0, 3'd7, 8'h00));
    // masking: bit 7 held pending while masked
    tbl.push_back(mk(8'h80, 8'h7F, 0, 8'h80, 0, 3'd7, 8'h00));
    tbl.push_back(mk(8'h80, 8'h7F, 0, 8'h80, 0, 3'd7, 8'h00));
    tbl.push_back(mk(8'h80, 8'hFF, 0, 8'h80, 1, 3'd7, 8'h80));
    tbl.push_back(mk(8'h80, 8'hFF, 1, 8'h00, 0, 3'd7, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 0, 8'h00, 0, 3'd7, 8'h00));
    // mask drops the serviced bit during ISSUE
    tbl.push_back(mk(8'h01, 8'hFF, 0, 8'h01, 0, 3'd7, 8'h01));
    tbl.push_back(mk(8'h01, 8'hFF, 0, 8'h01, 1, 3'd0, 8'h01));
    tbl.push_back(mk(8'h01, 8'hFE, 0, 8'h01, 1, 3'd0, 8'h00));
    tbl.push_back(mk(8'h01, 8'hFE, 1, 8'h00, 0, 3'd0, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 0, 8'h00, 0, 3'd0, 8'h00));
    // set/clear collision on bit 4
    tbl.push_back(mk(8'h10, 8'hFF, 0, 8'h10, 0, 3'd0, 8'h10));
    tbl.push_back(mk(8'h00, 8'hFF, 0, 8'h10, 1, 3'd4, 8'h10));
    tbl.push_back(mk(8'h10, 8'hFF, 1, 8'h10, 0, 3'd4, 8'h10));
    tbl.push_back(mk(8'h10, 8'hFF, 0, 8'h10, 0, 3'd4, 8'h10));
    tbl.push_back(mk(8'h10, 8'hFF, 0, 8'h10, 1, 3'd4, 8'h10));
    tbl.push_back(mk(8'h10, 8'hFF, 1, 8'h00, 0, 3'd4, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 0, 8'h00, 0, 3'd4, 8'h00));
    // ack in IDLE is ignored
    tbl.push_back(mk(8'h00, 8'hFF, 1, 8'h00, 0, 3'd4, 8'h00));
    tbl.push_back(mk(8'h20, 8'hFF, 1, 8'h20, 0, 3'd4, 8'h20));
    tbl.push_back(mk(8'h20, 8'hFF, 1, 8'h20, 1, 3'd5, 8'h20));
    tbl.push_back(mk(8'h20, 8'hFF, 1, 8'h00, 0, 3'd5, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 0, 8'h00, 0, 3'd5, 8'h00));

    rst_n    = 1'b0;
    bus.req  = 8'h00;
    bus.mask = 8'hFF;
    bus.ack  = 1'b0;
    #1;
    check_outputs("reset", ex(8'h00, 0, 3'd0, 8'h00));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step($sformatf("vec%0d", i), tbl[i].req, tbl[i].mask, tbl[i].ack, tbl[i].exp);
    end

    // Reset mid-ISSUE: drops irq and pending without a clock edge.
    step("rst_a", 8'h08, 8'hFF, 0, ex(8'h08, 0, 3'd5, 8'h08));
    step("rst_b", 8'h08, 8'hFF, 0, ex(8'h08, 1, 3'd3, 8'h08));
    #2;
    rst_n   = 1'b0;
    bus.ack = 1'b1;
    #1;
    check_outputs("rst_async", ex(8'h00, 0, 3'd0, 8'h00));
    @(posedge clk);
    #1;
    check_outputs("rst_held", ex(8'h00, 0, 3'd0, 8'h00));
    #2;
    rst_n = 1'b1;
    // req already high counts as a rise; held ack must not clear it in IDLE.
    step("rst_exit0", 8'h08, 8'hFF, 1, ex(8'h08, 0, 3'd0, 8'h08));
    step("rst_exit1", 8'h08, 8'hFF, 1, ex(8'h08, 1, 3'd3, 8'h08));
    step("rst_exit2", 8'h08, 8'hFF, 1, ex(8'h00, 0, 3'd3, 8'h00));
    step("rst_exit3", 8'h00, 8'hFF, 0, ex(8'h00, 0, 3'd3, 8'h00));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
